aes_round_sequencer: RTL and testbench

//   Iterative AES-128 encryption controller: owns state and round-key registers and drives one

---
 rtl/aes_round_sequencer_pkg.sv | 21 ++
 rtl/aes_round_sequencer.sv | 176 +++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sequencer_pkg.sv
// Shared definitions for the iterative AES-128 round sequencer.
//   AES_BLK_W      width of a state / key block
//   AES_RC_W       width of the round-number counter (rnd_rc)
//   AES128_ROUNDS  round count for AES-128
//   WAIT_W         width of the datapath-latency wait counter (RND_LAT 0..7)
//   seq_state_e    2-bit sequencer FSM encoding
package aes_round_sequencer_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int AES_RC_W      = 4;
  localparam int AES128_ROUNDS = 10;
  localparam int WAIT_W        = 3;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'b00,
    SEQ_ISSUE = 2'b01,
    SEQ_WAIT  = 2'b10,
    SEQ_DONE  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller. Holds the state and round-key
// registers and drives one external round datapath (Round / finalRound)
// NUM_ROUNDS times per block, with valid/ready framing on both sides.
//
// Parameters
//   NUM_ROUNDS   rounds per block; rnd_final marks the last one
//   RND_LAT      edges from rnd_issue until rnd_out/rnd_key_out are valid (0..7)
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     plain_text / c_key valid
//   in_ready     block accepted on an edge with in_valid & in_ready
//   plain_text   plaintext block
//   c_key        cipher key
//   rnd_state    registered state operand for the round datapath
//   rnd_key      registered key operand for the round datapath
//   rnd_rc       current round number 1..NUM_ROUNDS (key-schedule constant index)
//   rnd_final    datapath must use its finalRound result
//   rnd_issue    one-cycle pulse: fresh round operands presented
//   rnd_out      round result from the datapath
//   rnd_key_out  next round key from the datapath
//   out_valid    dataout holds a finished ciphertext
//   out_ready    sink accepts dataout
//   dataout      ciphertext
//   busy         a block is being processed (ISSUE or WAIT)
module aes_round_sequencer
  import aes_round_sequencer_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int RND_LAT    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] plain_text,
  input  logic [AES_BLK_W-1:0] c_key,
  output logic [AES_BLK_W-1:0] rnd_state,
  output logic [AES_BLK_W-1:0] rnd_key,
  output logic [AES_RC_W-1:0]  rnd_rc,
  output logic                 rnd_final,
  output logic                 rnd_issue,
  input  logic [AES_BLK_W-1:0] rnd_out,
  input  logic [AES_BLK_W-1:0] rnd_key_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] dataout,
  output logic                 busy
);

  localparam logic [AES_RC_W-1:0] LAST_ROUND = AES_RC_W'(NUM_ROUNDS);
  localparam logic [WAIT_W-1:0]   LAT_LOAD   = WAIT_W'(RND_LAT);

  seq_state_e fsm_q;
  seq_state_e fsm_d;

  logic [AES_BLK_W-1:0] state_q;
  logic [AES_BLK_W-1:0] key_q;
  logic [AES_RC_W-1:0]  round_q;
  logic [WAIT_W-1:0]    wait_q;

  logic load_block;
  logic capture;
  logic last_round;

  assign last_round = (round_q == LAST_ROUND);

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q <= SEQ_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next-state and handshake decode. With RND_LAT = 0 the datapath is purely
  // combinational, so the result is captured on the ISSUE edge itself and the
  // WAIT state is never entered. in_ready is masked during reset so no source
  // sees a ready while the block is being cleared.
  always_comb begin
    fsm_d      = fsm_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rnd_issue  = 1'b0;
    rnd_final  = 1'b0;
    busy       = 1'b0;
    load_block = 1'b0;
    capture    = 1'b0;
    case (fsm_q)
      SEQ_IDLE: begin
        in_ready = !reset;
        if (in_valid) begin
          load_block = 1'b1;
          fsm_d      = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        rnd_issue = 1'b1;
        busy      = 1'b1;
        rnd_final = last_round;
        if (RND_LAT == 0) begin
          capture = 1'b1;
          fsm_d   = last_round ? SEQ_DONE : SEQ_ISSUE;
        end else begin
          fsm_d = SEQ_WAIT;
        end
      end
      SEQ_WAIT: begin
        busy      = 1'b1;
        rnd_final = last_round;
        if (wait_q == WAIT_W'(1)) begin
          capture = 1'b1;
          fsm_d   = last_round ? SEQ_DONE : SEQ_ISSUE;
        end
      end
      SEQ_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          // A waiting block is loaded on the same edge the result drains.
          if (in_valid) begin
            load_block = 1'b1;
            fsm_d      = SEQ_ISSUE;
          end else begin
            fsm_d = SEQ_IDLE;
          end
        end
      end
      default: begin
        fsm_d = SEQ_IDLE;
      end
    endcase
  end

  // State/key/round registers. Loading a block applies the initial
  // AddRoundKey; each capture takes the datapath's round result and the next
  // round key. The round counter stops at the last round rather than wrapping.
  // The wait counter reloads every ISSUE and counts down in WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      wait_q  <= '0;
    end else begin
      if (load_block) begin
        state_q <= plain_text ^ c_key;
        key_q   <= c_key;
        round_q <= AES_RC_W'(1);
      end else if (capture) begin
        state_q <= rnd_out;
        key_q   <= rnd_key_out;
        if (!last_round) begin
          round_q <= round_q + AES_RC_W'(1);
        end
      end
      if (fsm_q == SEQ_ISSUE) begin
        wait_q <= LAT_LOAD;
      end else if (fsm_q == SEQ_WAIT) begin
        wait_q <= wait_q - WAIT_W'(1);
      end
    end
  end

  // Operands come straight from the registers so they stay stable from
  // ISSUE through the capture edge.
  always_comb begin
    rnd_state = state_q;
    rnd_key   = key_q;
    rnd_rc    = round_q;
    dataout   = state_q;
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer. Three instances share the
// clock: the main one (RND_LAT=1) and two for latency sweep (RND_LAT=0, 3).
// Each instance is served by a behavioural AES round datapath that only
// presents a correct result once its latency has elapsed. Expected
// ciphertexts are FIPS-197 vectors; a scoreboard queue carries them to a
// negedge monitor.
module tb_aes_round_sequencer;

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam int           MAIN_LATENCY = 20;

  typedef struct {
    logic [127:0] ct;
    int           edge_no;
  } exp_t;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plain_text;
  logic [127:0] c_key;
  logic [127:0] rnd_state;
  logic [127:0] rnd_key;
  logic [3:0]   rnd_rc;
  logic         rnd_final;
  logic         rnd_issue;
  logic [127:0] rnd_out;
  logic [127:0] rnd_key_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dataout;
  logic         busy;

  logic         in_valid_s;
  logic         in_ready_l0, in_ready_l3;
  logic [127:0] rnd_state_l0, rnd_state_l3;
  logic [127:0] rnd_key_l0, rnd_key_l3;
  logic [3:0]   rnd_rc_l0, rnd_rc_l3;
  logic         rnd_final_l0, rnd_final_l3;
  logic         rnd_issue_l0, rnd_issue_l3;
  logic [127:0] rnd_out_l0, rnd_out_l3;
  logic [127:0] rnd_key_out_l0, rnd_key_out_l3;
  logic         out_valid_l0, out_valid_l3;
  logic [127:0] dataout_l0, dataout_l3;
  logic         busy_l0, busy_l3;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t sb_q[$];

  aes_round_sequencer #(.NUM_ROUNDS(10), .RND_LAT(1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .plain_text(plain_text), .c_key(c_key), .rnd_state(rnd_state), .rnd_key(rnd_key),
    .rnd_rc(rnd_rc), .rnd_final(rnd_final), .rnd_issue(rnd_issue), .rnd_out(rnd_out),
    .rnd_key_out(rnd_key_out), .out_valid(out_valid), .out_ready(out_ready),
    .dataout(dataout), .busy(busy)
  );

  aes_round_sequencer #(.NUM_ROUNDS(10), .RND_LAT(0)) dut_l0 (
    .clock(clock), .reset(reset), .in_valid(in_valid_s), .in_ready(in_ready_l0),
    .plain_text(plain_text), .c_key(c_key), .rnd_state(rnd_state_l0), .rnd_key(rnd_key_l0),
    .rnd_rc(rnd_rc_l0), .rnd_final(rnd_final_l0), .rnd_issue(rnd_issue_l0), .rnd_out(rnd_out_l0),
    .rnd_key_out(rnd_key_out_l0), .out_valid(out_valid_l0), .out_ready(1'b1),
    .dataout(dataout_l0), .busy(busy_l0)
  );

  aes_round_sequencer #(.NUM_ROUNDS(10), .RND_LAT(3)) dut_l3 (
    .clock(clock), .reset(reset), .in_valid(in_valid_s), .in_ready(in_ready_l3),
    .plain_text(plain_text), .c_key(c_key), .rnd_state(rnd_state_l3), .rnd_key(rnd_key_l3),
    .rnd_rc(rnd_rc_l3), .rnd_final(rnd_final_l3), .rnd_issue(rnd_issue_l3), .rnd_out(rnd_out_l3),
    .rnd_key_out(rnd_key_out_l3), .out_valid(out_valid_l3), .out_ready(1'b1),
    .dataout(dataout_l3), .busy(busy_l3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // AES building blocks for the behavioural round datapath.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    logic [7:0] e;
    r  = 8'h01;
    sq = x;
    e  = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, sq);
      sq = gmul(sq, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // One AES round plus key expansion; returns {new_state, new_round_key}.
  function automatic logic [255:0] aes_round(input logic [127:0] st, input logic [127:0] key,
                                             input logic [3:0] rc, input logic fin);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   m[16];
    logic [31:0]  w[4];
    logic [31:0]  tmp;
    logic [7:0]   rcon;
    logic [127:0] nk;
    logic [127:0] ns;
    for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = s[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      if (fin) begin
        for (int r = 0; r < 4; r++) m[4*c+r] = t[4*c+r];
      end else begin
        m[4*c]   = xtime(t[4*c]) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
        m[4*c+1] = t[4*c] ^ xtime(t[4*c+1]) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
        m[4*c+2] = t[4*c] ^ t[4*c+1] ^ xtime(t[4*c+2]) ^ gmul(t[4*c+3], 8'h03);
        m[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ xtime(t[4*c+3]);
      end
    end
    for (int j = 0; j < 4; j++) w[j] = key[127-32*j -: 32];
    rcon = 8'h01;
    for (int i = 1; i < int'(rc); i++) rcon = xtime(rcon);
    tmp  = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])} ^ {rcon, 24'h0};
    w[0] = w[0] ^ tmp;
    w[1] = w[1] ^ w[0];
    w[2] = w[2] ^ w[1];
    w[3] = w[3] ^ w[2];
    nk   = {w[0], w[1], w[2], w[3]};
    for (int i = 0; i < 16; i++) ns[127-8*i -: 8] = m[i] ^ nk[127-8*i -: 8];
    return {ns, nk};
  endfunction

  // Datapath models: results are inverted (garbage) until RND_LAT edges
  // after rnd_issue, so an early capture corrupts the ciphertext.
  int           age_m = 0;
  int           age_3 = 0;
  logic [255:0] res_m;
  logic [255:0] res_3;

  always @(posedge clock) begin
    age_m <= rnd_issue ? 1 : ((age_m < 100) ? age_m + 1 : age_m);
    age_3 <= rnd_issue_l3 ? 1 : ((age_3 < 100) ? age_3 + 1 : age_3);
  end

  always_comb begin
    res_m = aes_round(rnd_state, rnd_key, rnd_rc, rnd_final);
    {rnd_out, rnd_key_out} = (!rnd_issue && age_m >= 1) ? res_m : ~res_m;
  end

  always_comb begin
    {rnd_out_l0, rnd_key_out_l0} = aes_round(rnd_state_l0, rnd_key_l0, rnd_rc_l0, rnd_final_l0);
  end

  always_comb begin
    res_3 = aes_round(rnd_state_l3, rnd_key_l3, rnd_rc_l3, rnd_final_l3);
    {rnd_out_l3, rnd_key_out_l3} = (!rnd_issue_l3 && age_3 >= 3) ? res_3 : ~res_3;
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Present one block on the main instance and wait (bounded) for acceptance.
  // The expected ciphertext and its out_valid edge go onto the scoreboard.
  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] key,
                               input logic [127:0] ct, output int acc_edge);
    int guard;
    exp_t e;
    acc_edge = -1;
    @(posedge clock);
    #2;
    in_valid   = 1'b1;
    plain_text = pt;
    c_key      = key;
    #1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clock);
      #3;
      guard++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 128'(in_ready), 128'd1);
    end else begin
      acc_edge  = cyc + 1;
      e.ct      = ct;
      e.edge_no = acc_edge + MAIN_LATENCY;
      sb_q.push_back(e);
      @(posedge clock);
      #2;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || busy) && guard < 300) begin
      @(posedge clock);
      #3;
      guard++;
    end
    if (sb_q.size() != 0) checkOutput("drain_timeout", 128'(sb_q.size()), 128'd0);
  endtask

  // Monitor: round-number sequencing, latency of each result and dataout
  // stability while out_valid is held.
  initial begin
    int exp_rc;
    bit head_seen;
    exp_rc    = 1;
    head_seen = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_rc    = 1;
        head_seen = 1'b0;
      end else begin
        if (rnd_issue) begin
          checkOutput("rnd_rc", 128'(rnd_rc), 128'(exp_rc));
          checkOutput("rnd_final", 128'(rnd_final), 128'(exp_rc == 10));
          exp_rc++;
        end
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_out_valid", 128'(out_valid), 128'd0);
          end else begin
            if (!head_seen) begin
              checkOutput("out_valid_edge", 128'(cyc), 128'(sb_q[0].edge_no));
              head_seen = 1'b1;
            end
            checkOutput("dataout", dataout, sb_q[0].ct);
            if (out_ready) begin
              void'(sb_q.pop_front());
              head_seen = 1'b0;
            end
          end
        end
        if (in_valid && in_ready) exp_rc = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc1;
    int acc2;
    int first0;
    int first3;
    logic [127:0] dout0;
    logic [127:0] dout3;

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_valid_s = 1'b0;
    out_ready  = 1'b1;
    plain_text = '0;
    c_key      = '0;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_in_ready", 128'(in_ready), 128'd0);
    checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
    checkOutput("reset_busy", 128'(busy), 128'd0);
    checkOutput("reset_dataout", dataout, 128'd0);
    checkOutput("reset_rnd_rc", 128'(rnd_rc), 128'd0);
    #1 reset = 1'b0;
    #1 checkOutput("release_in_ready", 128'(in_ready), 128'd1);

    // Test 1: FIPS-197 C.1.
    $display("[TB] test 1: FIPS-197 C.1 vector");
    applyStimulus(PT_C1, KEY_C1, CT_C1, acc1);
    waitIdle();

    // Test 2: back-to-back blocks with the sink always ready.
    $display("[TB] test 2: back-to-back blocks");
    applyStimulus(PT_C1, KEY_C1, CT_C1, acc1);
    applyStimulus(PT_B, KEY_B, CT_B, acc2);
    checkOutput("b2b_accept_edge", 128'(acc2), 128'(acc1 + MAIN_LATENCY + 1));
    waitIdle();

    // Test 3: sink stalls for 5 cycles in DONE while the source wiggles.
    $display("[TB] test 3: output backpressure");
    out_ready = 1'b0;
    applyStimulus(PT_B, KEY_B, CT_B, acc1);
    for (int i = 0; i < 100 && !out_valid; i++) begin
      @(posedge clock);
      #3;
    end
    checkOutput("stall_out_valid", 128'(out_valid), 128'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #2;
      in_valid   = i[0];
      plain_text = {$urandom, $urandom, $urandom, $urandom};
      #1;
      checkOutput("stall_in_ready", 128'(in_ready), 128'd0);
      checkOutput("stall_out_valid_held", 128'(out_valid), 128'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitIdle();

    // Test 4: reset during round 5, then rerun C.1.
    $display("[TB] test 4: reset mid-block");
    applyStimulus(PT_C1, KEY_C1, CT_C1, acc1);
    while (cyc < acc1 + 9) begin
      @(posedge clock);
      #2;
    end
    checkOutput("pre_reset_round", 128'(rnd_rc), 128'd5);
    reset = 1'b1;
    #1;
    sb_q.delete();
    checkOutput("midrst_in_ready", 128'(in_ready), 128'd0);
    checkOutput("midrst_busy", 128'(busy), 128'd0);
    checkOutput("midrst_rnd_issue", 128'(rnd_issue), 128'd0);
    checkOutput("midrst_rnd_final", 128'(rnd_final), 128'd0);
    checkOutput("midrst_rnd_rc", 128'(rnd_rc), 128'd0);
    checkOutput("midrst_rnd_state", rnd_state, 128'd0);
    checkOutput("midrst_rnd_key", rnd_key, 128'd0);
    checkOutput("midrst_dataout", dataout, 128'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checkOutput("postrst_in_ready", 128'(in_ready), 128'd1);
    checkOutput("postrst_out_valid", 128'(out_valid), 128'd0);
    repeat (5) @(posedge clock);
    applyStimulus(PT_C1, KEY_C1, CT_C1, acc1);
    waitIdle();

    // Test 6: a new block offered while busy is ignored.
    $display("[TB] test 6: input ignored while busy");
    applyStimulus(PT_C1, KEY_C1, CT_C1, acc1);
    repeat (4) @(posedge clock);
    #2;
    in_valid   = 1'b1;
    plain_text = PT_B;
    c_key      = KEY_B;
    #1;
    checkOutput("busy_in_ready", 128'(in_ready), 128'd0);
    @(posedge clock);
    #2 in_valid = 1'b0;
    waitIdle();

    // Test 5: latency sweep on the RND_LAT=0 and RND_LAT=3 instances.
    $display("[TB] test 5: RND_LAT sweep");
    first0 = -1;
    first3 = -1;
    dout0  = '0;
    dout3  = '0;
    @(posedge clock);
    #2;
    in_valid_s = 1'b1;
    plain_text = PT_C1;
    c_key      = KEY_C1;
    #1;
    checkOutput("sweep_ready_l0", 128'(in_ready_l0), 128'd1);
    checkOutput("sweep_ready_l3", 128'(in_ready_l3), 128'd1);
    acc1 = cyc + 1;
    @(posedge clock);
    #2 in_valid_s = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      #3;
      if (out_valid_l0 && first0 < 0) begin
        first0 = cyc;
        dout0  = dataout_l0;
      end
      if (out_valid_l3 && first3 < 0) begin
        first3 = cyc;
        dout3  = dataout_l3;
      end
    end
    checkOutput("lat0_out_valid_edge", 128'(first0), 128'(acc1 + 10));
    checkOutput("lat3_out_valid_edge", 128'(first3), 128'(acc1 + 40));
    checkOutput("lat0_dataout", dout0, CT_C1);
    checkOutput("lat3_dataout", dout3, CT_C1);

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
